// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side handshake between the 8-entry circular FIFO and its single
// consumer (the serial transmit stage).
//   empty  : FIFO empty flag, driven by the FIFO
//   r_data : FIFO head word, driven by the FIFO, valid whenever empty = 0
//   rd     : pop request, driven by the consumer (single-cycle pulse)
// Modports:
//   master : consumer side (drives rd)
//   slave  : FIFO side (drives empty and r_data)
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rd;

    modport master (
        input  empty,
        input  r_data,
        output rd
    );

    modport slave (
        output empty,
        output r_data,
        input  rd
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Serial transmit stage draining the FIFO read port. Each time the FIFO is
// non-empty while idle it pops one word and sends it as a frame: one start
// bit (low), DATA_WIDTH data bits LSB first, STOP_BITS stop bits (high).
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   fifo    : FIFO read-side interface (master: empty/r_data in, rd out)
//   tx      : serial line, idles high, driven from a flop
//   busy    : high from frame start to the end of the last stop bit
//   tx_done : one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    // Stop-period index only needs to distinguish one or two stop bits.
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                state_r;
    logic [TW-1:0]         tick_r;
    logic [BW-1:0]         bit_idx_r;
    logic                  stop_idx_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  rd_r;
    logic                  tx_r;
    logic                  busy_r;
    logic                  tx_done_r;

    logic                  tick_end_s;
    logic [DATA_WIDTH-1:0] shift_next_s;

    // Bit-period end flag and the shift register contents after one shift.
    always_comb begin
        tick_end_s   = (tick_r == TICK_LAST);
        shift_next_s = shift_r >> 1;
    end

    // Frame state machine; every output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            tick_r     <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            shift_r    <= '0;
            rd_r       <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            rd_r      <= 1'b0;
            tx_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    if (!fifo.empty) begin
                        // Capture the head word and pop it on the next edge;
                        // the start bit begins right here.
                        shift_r   <= fifo.r_data;
                        rd_r      <= 1'b1;
                        tick_r    <= '0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_START;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_end_s) begin
                        tick_r    <= '0;
                        bit_idx_r <= '0;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        tick_r    <= tick_r + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_end_s) begin
                        tick_r <= '0;
                        if (bit_idx_r == BIT_LAST) begin
                            tx_r       <= 1'b1;
                            stop_idx_r <= 1'b0;
                            state_r    <= ST_STOP;
                        end else begin
                            bit_idx_r  <= bit_idx_r + BW'(1);
                            shift_r    <= shift_next_s;
                            tx_r       <= shift_next_s[0];
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
                    end
                end
                ST_STOP: begin
                    tx_r <= 1'b1;
                    if (tick_end_s) begin
                        tick_r <= '0;
                        if (stop_idx_r == STOP_LAST) begin
                            busy_r    <= 1'b0;
                            tx_done_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle line.
                    state_r <= ST_IDLE;
                    tick_r  <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.rd = rd_r;
    assign tx      = tx_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with an 8-entry FIFO model on the read port.
// Written words go into the FIFO model and into a scoreboard queue; an
// independent monitor decodes every frame on tx cycle by cycle against the
// ideal 8N1 waveform of the next expected word.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
    localparam int DW         = 8;
    localparam int CPB        = 4;
    localparam int SB         = 1;
    localparam int DEPTH      = 8;
    localparam int FRAME_BITS = 1 + DW + SB;
    localparam int FRAME_CYC  = FRAME_BITS * CPB;
    localparam int TIMEOUT    = 5000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic busy;
    logic tx_done;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) fifo_bus ();

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .fifo   (fifo_bus),
        .tx     (tx),
        .busy   (busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_q[$];
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          empty_r = 1'b1;
    logic [DW-1:0] head_r  = '0;

    assign fifo_bus.empty  = empty_r;
    assign fifo_bus.r_data = head_r;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q.delete();
            empty_r <= 1'b1;
            head_r  <= '0;
        end else begin
            if (fifo_bus.rd === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(wr_data);
            empty_r <= (fifo_q.size() == 0);
            head_r  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // ---------------- scoreboard and monitor ----------------
    logic [DW-1:0] exp_q[$];
    int            words_sent = 0;
    int            rd_seen    = 0;
    int            frames     = 0;
    bit            mon_active = 1'b0;
    int            mon_k      = 0;
    bit            mon_bad    = 1'b0;
    int            mon_bad_k  = 0;
    bit            want_next  = 1'b0;
    logic [DW-1:0] mon_exp    = '0;
    logic [DW-1:0] mon_word   = '0;

    always @(negedge clk) begin
        if (reset && fifo_bus.rd === 1'b1) rd_seen++;
    end

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
            want_next  = 1'b0;
        end else begin
            if (!mon_active) begin
                if (want_next) begin
                    checks++;
                    if (tx !== 1'b0) begin
                        errors++;
                        $display("FAIL gap: tx=%b after one idle cycle, required 0 (next frame start)", tx);
                    end
                    want_next = 1'b0;
                end
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_k      = 0;
                    mon_bad    = 1'b0;
                    mon_word   = '0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: frame started with no word queued, required none");
                        mon_exp = '0;
                    end else begin
                        mon_exp = exp_q.pop_front();
                    end
                end
            end
            if (mon_active) begin
                if (mon_k < FRAME_CYC) begin
                    int   j;
                    logic eb;
                    logic er;
                    j  = mon_k / CPB;
                    eb = (j == 0) ? 1'b0 : ((j <= DW) ? mon_exp[j-1] : 1'b1);
                    er = (mon_k == 0);
                    if (j >= 1 && j <= DW && (mon_k % CPB) == CPB / 2) mon_word[j-1] = tx;
                    if ((tx !== eb || busy !== 1'b1 || tx_done !== 1'b0 || fifo_bus.rd !== er) && !mon_bad) begin
                        mon_bad   = 1'b1;
                        mon_bad_k = mon_k;
                    end
                    mon_k++;
                end else begin
                    checks++;
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL frame: decoded %0d (first bad cycle %0d), required %0d", mon_word, mon_bad_k, mon_exp);
                    end
                    checks++;
                    if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_end: tx_done=%b busy=%b tx=%b at cycle %0d, required 1 0 1", tx_done, busy, tx, FRAME_CYC);
                    end
                    frames++;
                    mon_active = 1'b0;
                    want_next  = (fifo_bus.empty === 1'b0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Caller must be at a falling edge.
    task automatic fifo_write(input logic [DW-1:0] v);
        if (fifo_q.size() < DEPTH) begin
            exp_q.push_back(v);
            words_sent++;
        end
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || busy !== 1'b0 || fifo_q.size() != 0) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, (n >= TIMEOUT) ? 1 : 0, 0);
        repeat (3) @(negedge clk);
        check({name, "_rd_count"}, rd_seen, words_sent);
        check({name, "_empty"}, int'(fifo_bus.empty), 1);
    endtask

    task automatic wait_k(input string name, input int k);
        int n = 0;
        while (!(mon_active && mon_k >= k) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_wait_timeout"}, (n >= TIMEOUT) ? 1 : 0, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] full_vals [DEPTH];
        int            fr;

        full_vals = '{8'd5, 8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6};

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_rd", int'(fifo_bus.rd), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_done", int'(tx_done), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_rd", rd_seen, 0);
        check("idle_no_frame", frames, 0);

        // Single frame
        fifo_write(8'hA5);
        wait_drain("single");
        check("single_frames", frames, 1);

        // Three queued words back-to-back
        fifo_write(8'd12);
        fifo_write(8'd4);
        fifo_write(8'd23);
        wait_drain("three");
        check("three_frames", frames, 4);

        // Full FIFO: fill all entries while a leading frame is on the line
        fifo_write(8'd1);
        wait_k("full_lead", 3);
        fr = frames;
        for (int i = 0; i < DEPTH; i++) fifo_write(full_vals[i]);
        @(negedge clk);
        check("full_no_pop_mid_frame", fifo_q.size(), DEPTH);
        while (frames == fr && mon_active) @(negedge clk);
        repeat (3) @(negedge clk);
        check("full_one_pop_after_frame", fifo_q.size(), DEPTH - 1);
        wait_drain("full");

        // Write during a frame
        fifo_write(8'd11);
        wait_k("midwrite", 20);
        fifo_write(8'd17);
        wait_drain("midwrite");

        // Randomised words with random spacing
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            fifo_write(DW'($urandom_range(0, 255)));
        end
        wait_drain("random");

        // Reset during data bit 3 of 8'hFF
        fifo_write(8'hFF);
        wait_k("rst_mid", 17);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_rd", int'(fifo_bus.rd), 0);
        exp_q.delete();
        fr = frames;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_after_no_rd", rd_seen, words_sent);
        check("rst_after_no_frame", frames, fr);
        check("rst_after_tx_idle", int'(tx), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
